// File: rtl/hanoi_towers_if.sv
// Move-proposal / board-state bundle between a Hanoi solver (master) and the
// board (slave). rings packs one PW-bit peg field per ring, ring 0 in the LSBs.
interface hanoi_towers_if #(
    parameter int N  = 3,
    parameter int M  = 3,
    parameter int IW = $clog2(N),
    parameter int PW = $clog2(M)
);
    logic [IW-1:0]   ind;
    logic [PW-1:0]   loc;
    logic [N*PW-1:0] rings;
    logic            move_ok;
    logic            done;

    modport master (output ind, loc, input rings, move_ok, done);
    modport slave  (input ind, loc, output rings, move_ok, done);
endinterface

// File: rtl/hanoi_towers.sv
// Towers-of-Hanoi board: applies one legal proposed move per clock and exposes
// the peg of every ring straight from the state register.
module hanoi_towers #(
    parameter int N = 3,
    parameter int M = 3
) (
    input  logic          clk,
    input  logic          rst,
    hanoi_towers_if.slave bus
);
    localparam int PW = $clog2(M);
    localparam logic [PW-1:0] LAST_PEG = PW'(M - 1);

    logic [N-1:0][PW-1:0] rings_q, rings_d;
    logic                 move_ok_q, move_ok_d;
    logic [PW-1:0]        src;
    logic                 legal;

    always_comb begin
        src   = '0;
        legal = (int'(bus.ind) < N) && (int'(bus.loc) < M);
        // Loop-select the source field so an out-of-range ind never indexes rings_q.
        for (int i = 0; i < N; i++) begin
            if (i == int'(bus.ind)) src = rings_q[i];
        end
        if (bus.loc == src) legal = 1'b0;
        // Any smaller ring on the source or destination peg blocks the move.
        for (int j = 0; j < N; j++) begin
            if (j < int'(bus.ind) && (rings_q[j] == src || rings_q[j] == bus.loc))
                legal = 1'b0;
        end
    end

    always_comb begin
        rings_d   = rings_q;
        move_ok_d = legal;
        for (int i = 0; i < N; i++) begin
            if (legal && i == int'(bus.ind)) rings_d[i] = bus.loc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rings_q   <= '0;
            move_ok_q <= 1'b0;
        end else begin
            rings_q   <= rings_d;
            move_ok_q <= move_ok_d;
        end
    end

    always_comb begin
        bus.done = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (rings_q[i] != LAST_PEG) bus.done = 1'b0;
        end
    end

    assign bus.rings   = rings_q;
    assign bus.move_ok = move_ok_q;
endmodule

// File: tb/tb_hanoi_towers.sv
// Self-checking bench for hanoi_towers: directed Hanoi scenarios plus random
// moves, checked against a peg-stack model of the board.
module tb_hanoi_towers;
    localparam int N  = 3;
    localparam int M  = 3;
    localparam int IW = 2;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hanoi_towers_if #(.N(N), .M(M)) bus ();
    hanoi_towers #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   st[M][$];   // each peg as a stack of ring indices, top at the back
    logic m_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*PW-1:0] m_rings();
        logic [N*PW-1:0] r = '0;
        for (int p = 0; p < M; p++)
            foreach (st[p][k]) r[st[p][k]*PW +: PW] = p[PW-1:0];
        return r;
    endfunction

    task automatic model_step(input int i, input int l, input logic r);
        int src;
        m_ok = 1'b0;
        if (!r) begin
            for (int p = 0; p < M; p++) st[p].delete();
            for (int k = N - 1; k >= 0; k--) st[0].push_back(k);
        end else if (i < N && l < M) begin
            src = 0;
            for (int p = 0; p < M; p++)
                foreach (st[p][k]) if (st[p][k] == i) src = p;
            if (src != l && st[src][$] == i && (st[l].size() == 0 || st[l][$] > i)) begin
                void'(st[src].pop_back());
                st[l].push_back(i);
                m_ok = 1'b1;
            end
        end
    endtask

    task automatic step(input int i, input int l, input logic r, input string tag);
        @(negedge clk);
        bus.ind = i[IW-1:0];
        bus.loc = l[PW-1:0];
        rst     = r;
        @(posedge clk);
        #1;
        model_step(i, l, r);
        chk({tag, ".rings"},   32'(bus.rings), 32'(m_rings()));
        chk({tag, ".move_ok"}, 32'(bus.move_ok), 32'(m_ok));
        chk({tag, ".done"},    32'(bus.done), 32'(st[M-1].size() == N));
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++)
            step($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, "reset");
    endtask

    int sol_i[7]   = '{0, 1, 0, 2, 0, 1, 0};
    int sol_l[7]   = '{2, 1, 1, 2, 0, 2, 2};
    int sol_hex[7] = '{'h02, 'h06, 'h05, 'h25, 'h24, 'h28, 'h2A};

    initial begin
        bus.ind = '0;
        bus.loc = '0;

        do_reset(2);
        chk("reset.rings_const", 32'(bus.rings), 32'h0);
        chk("reset.done_const",  32'(bus.done), 32'h0);

        for (int k = 0; k < 7; k++) begin
            step(sol_i[k], sol_l[k], 1'b1, "solve");
            chk("solve.hex", 32'(bus.rings), 32'(sol_hex[k]));
            chk("solve.ok_const", 32'(bus.move_ok), 32'h1);
        end
        chk("solve.done_const", 32'(bus.done), 32'h1);

        step(0, 0, 1'b1, "unsolve");
        chk("unsolve.hex", 32'(bus.rings), 32'h28);
        chk("unsolve.done_const", 32'(bus.done), 32'h0);

        do_reset(1);
        step(2, 1, 1'b1, "buried");
        chk("buried.ok_const", 32'(bus.move_ok), 32'h0);
        step(0, 1, 1'b1, "buried");
        step(1, 1, 1'b1, "buried");
        chk("buried.hex", 32'(bus.rings), 32'h01);
        chk("buried.ok2_const", 32'(bus.move_ok), 32'h0);

        do_reset(1);
        step(0, 0, 1'b1, "samepeg");
        step(0, 3, 1'b1, "badloc");
        step(3, 0, 1'b1, "badind");
        chk("range.hex", 32'(bus.rings), 32'h00);
        chk("range.ok_const", 32'(bus.move_ok), 32'h0);

        do_reset(1);
        for (int k = 0; k < 4; k++) step(sol_i[k], sol_l[k], 1'b1, "pre");
        chk("pre.hex", 32'(bus.rings), 32'h25);
        step(0, 0, 1'b0, "midreset");
        chk("midreset.hex", 32'(bus.rings), 32'h00);
        for (int k = 0; k < 7; k++) step(sol_i[k], sol_l[k], 1'b1, "resolve");
        chk("resolve.hex", 32'(bus.rings), 32'h2A);

        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 59) != 0), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hanoi_towers.md
Name:
hanoi_towers

Overview:
- Towers-of-Hanoi state machine holding the peg position of every ring.
- Each clock, a driver proposes a move (ring index `ind`, destination peg `loc`). The block applies the move only if it is legal under Hanoi rules, and exposes the full board state on `rings`.
- Used as a formal-verification target and driven by a solver/stimulus that computes the next move combinationally from `rings`.

Parameters:
- N, 3, number of rings; ring 0 is the smallest, ring N-1 the largest; N>=2.
- M, 3, number of pegs; M>=3.
- Derived: IW = $clog2(N) (ring-index width), PW = $clog2(M) (peg-index width).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-low reset.
- ind  in  IW  ring index of the proposed move.
- loc  in  PW  destination peg of the proposed move.
- rings  out  N*PW  board state; field i = rings[(i+1)*PW-1 -: PW] = peg currently holding ring i.
- move_ok  out  1  registered; 1 if the move sampled at the previous edge was applied.
- done  out  1  1 when every ring field equals M-1.

Behaviour:
- Reset: on rising clk with rst==0:
  - all ring fields = 0, i.e. rings = 0 and all rings on peg 0;
  - move_ok = 0;
  - done = 0.
- Reset has priority over any move, including a reset asserted mid-sequence.
- Move evaluation, every rising clk with rst==1, using the current registered rings, `ind` and `loc`. The move is legal iff all of the following hold:
  - ind < N and loc < M (out-of-range values are illegal);
  - src = field[ind]; loc != src (a same-peg move is illegal);
  - no ring j < ind has field[j] == src (ring ind is on top of its peg);
  - no ring j < ind has field[j] == loc (destination top is larger or empty).
- Legal move: field[ind] <= loc. All other fields are unchanged. move_ok <= 1.
- Illegal move: rings unchanged; move_ok <= 0.
- Exactly one ring moves per cycle; no move is ever dropped or queued.
- Latency: one cycle. rings reflects the move on the edge that sampled it.
- rings must be driven directly from the state register, with no combinational path from ind/loc, because drivers compute the next move combinationally from rings.
- done is combinational from registered rings: 1 iff every field == M-1. done is not sticky; it drops if a later legal move leaves peg M-1.
- The invariant holds in every reachable state: no larger ring lies above a smaller one.
- Pegs do not wrap inside the block; wrap-around is the driver's concern.
- Unused peg codes (M not a power of two) are never written.

Test Plan (N=3, M=3, PW=2; rings shown as hex of 6 bits):
- Reset: hold rst=0 for 2 cycles with arbitrary ind/loc -> rings=0x00, move_ok=0, done=0.
- Optimal solve: release rst, then apply (ind,loc) = (0,2),(1,1),(0,1),(2,2),(0,0),(1,2),(0,2), one per cycle.
  - Each cycle gives move_ok=1.
  - rings steps through 0x02,0x06,0x05,0x25,0x24,0x28,0x2A.
  - done=1 after the 7th move.
- Buried ring: from reset, (2,1) -> move_ok=0, rings stays 0x00.
  - Then (0,1),(1,1) -> the second move is rejected (a smaller ring is on the destination), rings=0x01.
- Same-peg and out-of-range moves: from reset, (0,0) -> move_ok=0.
  - loc=3 -> move_ok=0.
  - ind=3 -> move_ok=0.
  - rings unchanged in all three cases.
- Reset mid-sequence: after 4 legal solve moves (rings=0x25), pulse rst=0 for one cycle while ind/loc present a legal move -> rings=0x00, move_ok=0.
  - Resuming the solve sequence from its start reaches 0x2A.
- Non-sticky done: after the solve, apply (0,0) -> move_ok=1, rings=0x28, done=0.
